// File: rtl/ex_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_ctrl_pkg
// Brief    : Shared EX-stage encodings: FSM states, ALUOp and funct codes.
// Revision : 1.0 - initial release
// ============================================================================
package ex_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_MUL_WAIT   = 2'd1,
        ST_LOAD_STALL = 2'd2,
        ST_BR_FLUSH   = 2'd3
    } state_e;

    localparam logic [1:0] C_ALUOP_MEM   = 2'b00;  // LW / SW / ADDI
    localparam logic [1:0] C_ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] C_ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] C_FUNCT_ADD = 6'd0;
    localparam logic [5:0] C_FUNCT_SUB = 6'd1;
    localparam logic [5:0] C_FUNCT_MUL = 6'd2;

    localparam int C_MUL_CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/ex_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_hazard_ctrl_if
// Brief    : Pipeline <-> hazard controller signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface ex_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs_addr;
    logic [4:0]       id_rt_addr;
    logic             id_uses_rt;
    logic             ex_valid;
    logic             ex_mem_read;
    logic [4:0]       ex_rt_addr;
    logic             ex_is_mul;
    logic             ex_branch;
    logic             ex_zero;

    logic             stall_flag_if;
    logic             stall_flag_id;
    logic             stall_flag_ex;
    logic             ex_bubble;
    logic             flush_id;
    logic             mul_done;
    logic [1:0]       state_out;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_valid, id_rs_addr, id_rt_addr, id_uses_rt,
        output ex_valid, ex_mem_read, ex_rt_addr, ex_is_mul, ex_branch, ex_zero,
        input  stall_flag_if, stall_flag_id, stall_flag_ex, ex_bubble,
        input  flush_id, mul_done, state_out, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rt_addr, id_uses_rt,
        input  ex_valid, ex_mem_read, ex_rt_addr, ex_is_mul, ex_branch, ex_zero,
        output stall_flag_if, stall_flag_id, stall_flag_ex, ex_bubble,
        output flush_id, mul_done, state_out, stall_cycles
    );

endinterface
`default_nettype wire

// File: rtl/ex_hazard_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : hazard_detect
// Brief    : Combinational raw event detection (taken branch, MUL, load-use).
// Revision : 1.0 - initial release
// ============================================================================
module hazard_detect (
    input  wire logic       i_id_valid,
    input  wire logic [4:0] i_id_rs_addr,
    input  wire logic [4:0] i_id_rt_addr,
    input  wire logic       i_id_uses_rt,
    input  wire logic       i_ex_valid,
    input  wire logic       i_ex_mem_read,
    input  wire logic [4:0] i_ex_rt_addr,
    input  wire logic       i_ex_is_mul,
    input  wire logic       i_ex_branch,
    input  wire logic       i_ex_zero,
    output logic            o_taken,
    output logic            o_mul,
    output logic            o_lduse
);

    logic w_rs_match;
    logic w_rt_match;

    always_comb begin
        w_rs_match = (i_id_rs_addr == i_ex_rt_addr);
        w_rt_match = i_id_uses_rt && (i_id_rt_addr == i_ex_rt_addr);
        o_taken    = i_ex_branch && i_ex_zero;
        o_mul      = i_ex_valid && i_ex_is_mul;
        // Writes to $zero are discarded, so they can never create a hazard
        o_lduse    = i_ex_valid && i_ex_mem_read && i_id_valid &&
                     (i_ex_rt_addr != 5'd0) && (w_rs_match || w_rt_match);
    end

endmodule
`default_nettype wire

// File: rtl/ex_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ex_hazard_ctrl
// Brief    : EX-stage stall/flush FSM with multi-cycle MUL and stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module ex_hazard_ctrl
    import ex_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  wire logic        clk,
    input  wire logic        reset,
    ex_hazard_ctrl_if.slave  bus
);

    localparam logic [C_MUL_CNT_W-1:0] C_CNT_LOAD = C_MUL_CNT_W'(MUL_CYCLES - 2);

    logic w_taken;
    logic w_mul;
    logic w_lduse;

    state_e                 state_q,        state_d;
    logic [C_MUL_CNT_W-1:0] cnt_q,          cnt_d;
    logic                   stall_if_q,     stall_if_d;
    logic                   stall_ex_q,     stall_ex_d;
    logic                   bubble_q,       bubble_d;
    logic                   flush_q,        flush_d;
    logic                   mul_done_q,     mul_done_d;
    logic [CNT_W-1:0]       stall_cycles_q, stall_cycles_d;

    hazard_detect u_hazard_detect (
        .i_id_valid    (bus.id_valid),
        .i_id_rs_addr  (bus.id_rs_addr),
        .i_id_rt_addr  (bus.id_rt_addr),
        .i_id_uses_rt  (bus.id_uses_rt),
        .i_ex_valid    (bus.ex_valid),
        .i_ex_mem_read (bus.ex_mem_read),
        .i_ex_rt_addr  (bus.ex_rt_addr),
        .i_ex_is_mul   (bus.ex_is_mul),
        .i_ex_branch   (bus.ex_branch),
        .i_ex_zero     (bus.ex_zero),
        .o_taken       (w_taken),
        .o_mul         (w_mul),
        .o_lduse       (w_lduse)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mul_done_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (w_taken) begin
                    state_d = ST_BR_FLUSH;
                end else if (w_mul) begin
                    state_d = ST_MUL_WAIT;
                    cnt_d   = C_CNT_LOAD;
                end else if (w_lduse) begin
                    state_d = ST_LOAD_STALL;
                end
            end
            ST_MUL_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = ST_IDLE;
                    mul_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_LOAD_STALL: state_d = ST_IDLE;
            ST_BR_FLUSH:   state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they register alongside it
        stall_if_d = (state_d == ST_MUL_WAIT) || (state_d == ST_LOAD_STALL);
        stall_ex_d = (state_d == ST_MUL_WAIT);
        bubble_d   = (state_d == ST_LOAD_STALL);
        flush_d    = (state_d == ST_BR_FLUSH);

        stall_cycles_d = stall_cycles_q;
        if (stall_if_q && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            stall_if_q     <= 1'b0;
            stall_ex_q     <= 1'b0;
            bubble_q       <= 1'b0;
            flush_q        <= 1'b0;
            mul_done_q     <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_if_q     <= stall_if_d;
            stall_ex_q     <= stall_ex_d;
            bubble_q       <= bubble_d;
            flush_q        <= flush_d;
            mul_done_q     <= mul_done_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.stall_flag_if = stall_if_q;
    assign bus.stall_flag_id = stall_if_q;
    assign bus.stall_flag_ex = stall_ex_q;
    assign bus.ex_bubble     = bubble_q;
    assign bus.flush_id      = flush_q;
    assign bus.mul_done      = mul_done_q;
    assign bus.state_out     = state_q;
    assign bus.stall_cycles  = stall_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_hazard_ctrl
// Brief    : Directed self-checking bench for ex_hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_hazard_ctrl;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    ex_hazard_ctrl_if #(.CNT_W(4)) bus ();

    ex_hazard_ctrl #(
        .MUL_CYCLES (4),
        .CNT_W      (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // stall_if, stall_id, stall_ex, bubble, flush, mul_done, state
    task automatic check_outs(input string tag, input logic sif, input logic sex,
                              input logic bub, input logic fl, input logic md,
                              input logic [1:0] st);
        check({tag, ".stall_if"}, {31'd0, bus.stall_flag_if}, {31'd0, sif});
        check({tag, ".stall_id"}, {31'd0, bus.stall_flag_id}, {31'd0, sif});
        check({tag, ".stall_ex"}, {31'd0, bus.stall_flag_ex}, {31'd0, sex});
        check({tag, ".bubble"},   {31'd0, bus.ex_bubble},     {31'd0, bub});
        check({tag, ".flush"},    {31'd0, bus.flush_id},      {31'd0, fl});
        check({tag, ".mul_done"}, {31'd0, bus.mul_done},      {31'd0, md});
        check({tag, ".state"},    {30'd0, bus.state_out},     {30'd0, st});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_valid    = 1'b0;
        bus.id_rs_addr  = 5'd0;
        bus.id_rt_addr  = 5'd0;
        bus.id_uses_rt  = 1'b0;
        bus.ex_valid    = 1'b0;
        bus.ex_mem_read = 1'b0;
        bus.ex_rt_addr  = 5'd0;
        bus.ex_is_mul   = 1'b0;
        bus.ex_branch   = 1'b0;
        bus.ex_zero     = 1'b0;
    endtask

    task automatic set_lduse(input logic [4:0] ex_rt, input logic [4:0] rs,
                             input logic [4:0] rt, input logic uses_rt);
        bus.ex_valid    = 1'b1;
        bus.ex_mem_read = 1'b1;
        bus.ex_rt_addr  = ex_rt;
        bus.id_valid    = 1'b1;
        bus.id_rs_addr  = rs;
        bus.id_rt_addr  = rt;
        bus.id_uses_rt  = uses_rt;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        clear_inputs();
        #22;
        check_outs("reset", 0, 0, 0, 0, 0, 2'd0);
        check("reset.cnt", {28'd0, bus.stall_cycles}, 32'd0);
        reset = 1'b1;
        step();
        check_outs("idle", 0, 0, 0, 0, 0, 2'd0);

        // MUL issued at edge N: three stall cycles then a single mul_done
        bus.ex_valid  = 1'b1;
        bus.ex_is_mul = 1'b1;
        step();
        clear_inputs();
        check_outs("mul.c1", 1, 1, 0, 0, 0, 2'd1);
        step();
        check_outs("mul.c2", 1, 1, 0, 0, 0, 2'd1);
        step();
        check_outs("mul.c3", 1, 1, 0, 0, 0, 2'd1);
        step();
        check_outs("mul.c4", 0, 0, 0, 0, 1, 2'd0);
        check("mul.stall_cycles", {28'd0, bus.stall_cycles}, 32'd3);
        step();
        check_outs("mul.c5", 0, 0, 0, 0, 0, 2'd0);

        // Load-use on rs
        set_lduse(5'd8, 5'd8, 5'd0, 1'b0);
        step();
        clear_inputs();
        check_outs("lduse.stall", 1, 0, 1, 0, 0, 2'd2);
        check("lduse.cnt_hold", {28'd0, bus.stall_cycles}, 32'd3);
        step();
        check_outs("lduse.idle", 0, 0, 0, 0, 0, 2'd0);
        check("lduse.cnt", {28'd0, bus.stall_cycles}, 32'd4);

        set_lduse(5'd0, 5'd0, 5'd0, 1'b0);
        step();
        check_outs("lduse.zero", 0, 0, 0, 0, 0, 2'd0);

        // rt path only matters when the instruction reads rt
        set_lduse(5'd9, 5'd1, 5'd9, 1'b0);
        step();
        check_outs("rt.unused", 0, 0, 0, 0, 0, 2'd0);
        set_lduse(5'd9, 5'd1, 5'd9, 1'b1);
        step();
        clear_inputs();
        check_outs("rt.used", 1, 0, 1, 0, 0, 2'd2);
        step();
        check_outs("rt.idle", 0, 0, 0, 0, 0, 2'd0);
        check("rt.cnt", {28'd0, bus.stall_cycles}, 32'd5);

        // Taken branch wins over a simultaneous MUL
        bus.ex_branch = 1'b1;
        bus.ex_zero   = 1'b1;
        bus.ex_valid  = 1'b1;
        bus.ex_is_mul = 1'b1;
        step();
        clear_inputs();
        check_outs("br.flush", 0, 0, 0, 1, 0, 2'd3);
        step();
        check_outs("br.idle", 0, 0, 0, 0, 0, 2'd0);
        step();
        check_outs("br.no_mul", 0, 0, 0, 0, 0, 2'd0);
        check("br.cnt", {28'd0, bus.stall_cycles}, 32'd5);

        // Asynchronous reset in the middle of a MUL
        bus.ex_valid  = 1'b1;
        bus.ex_is_mul = 1'b1;
        step();
        clear_inputs();
        step();
        check_outs("rmul.busy", 1, 1, 0, 0, 0, 2'd1);
        #2;
        reset = 1'b0;
        #1;
        check_outs("rmul.async", 0, 0, 0, 0, 0, 2'd0);
        check("rmul.cnt", {28'd0, bus.stall_cycles}, 32'd0);
        #3;
        reset = 1'b1;
        step();
        check_outs("rmul.rel1", 0, 0, 0, 0, 0, 2'd0);
        step();
        check_outs("rmul.rel2", 0, 0, 0, 0, 0, 2'd0);

        // Back-to-back load-use stalls saturate the 4-bit counter
        set_lduse(5'd8, 5'd8, 5'd0, 1'b0);
        for (int i = 0; i < 28; i++) step();
        check("sat.14", {28'd0, bus.stall_cycles}, 32'd14);
        for (int i = 0; i < 2; i++) step();
        check("sat.15", {28'd0, bus.stall_cycles}, 32'd15);
        for (int i = 0; i < 10; i++) step();
        check("sat.hold", {28'd0, bus.stall_cycles}, 32'd15);
        clear_inputs();
        step();
        check_outs("sat.idle", 0, 0, 0, 0, 0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
